// File: rtl/rle_stream_if.sv
// Coefficient-in / symbol-out stream bundle for the RLE sequencer.
// The controller takes the slave side; the producer/sink environment takes master.
interface rle_stream_if #(
  parameter int SYM_W = 14
) ();
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SYM_W-1:0] out_sym;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );
endinterface

// File: rtl/rle_stream_ctrl.sv
// Collects a zig-zag block for the combinational RLE, captures its result and
// streams symbols out through EOB; filling the next block overlaps emission.
//
//  state | meaning
//  FILL  | input buffer accepting bytes at index wr_cnt
//  FULL  | block closed, waiting for the emitter to take the RLE result
//  IDLE  | emitter empty
//  EMIT  | presenting symbol slot rd_cnt of sym_reg
module rle_stream_ctrl #(
  parameter int               NCOEF   = 64,
  parameter int               SYM_W   = 14,
  parameter logic [SYM_W-1:0] EOB_SYM = 14'h3FFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rle_stream_if.slave              strm,
  output logic [NCOEF*8-1:0]       rle_din,
  input  logic [NCOEF*SYM_W-1:0]   rle_dout,
  output logic                     blk_err,
  output logic                     busy
);
  localparam int            CW       = $clog2(NCOEF);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCOEF - 1);

  typedef enum logic {FILL, FULL} in_state_t;
  typedef enum logic {IDLE, EMIT} em_state_t;

  in_state_t                in_state;
  em_state_t                em_state;
  logic [NCOEF*8-1:0]       blk_buf;
  logic [NCOEF*SYM_W-1:0]   sym_reg;
  logic [CW-1:0]            wr_cnt;
  logic [CW-1:0]            rd_cnt;
  logic                     blk_err_q;
  logic [SYM_W-1:0]         cur_slot;
  logic                     sym_last;
  logic                     accept;
  logic                     fire;
  logic                     cap;

  // Slots are packed MSB-first: slot 0 occupies the top SYM_W bits.
  assign cur_slot = sym_reg[SYM_W*(NCOEF-1-int'(rd_cnt)) +: SYM_W];
  assign sym_last = (em_state == EMIT) && ((cur_slot == EOB_SYM) || (rd_cnt == LAST_IDX));

  assign accept = strm.in_valid && (in_state == FILL);
  assign fire   = (em_state == EMIT) && strm.out_ready;
  // Capture may coincide with the final handshake so back-to-back blocks emit without a bubble.
  assign cap    = (in_state == FULL) && ((em_state == IDLE) || (fire && sym_last));

  assign strm.in_ready  = (in_state == FILL);
  assign strm.out_valid = (em_state == EMIT);
  assign strm.out_sym   = (em_state == EMIT) ? cur_slot : '0;
  assign strm.out_last  = sym_last;
  assign rle_din        = blk_buf;
  assign blk_err        = blk_err_q;
  assign busy           = (in_state == FULL) || (em_state == EMIT) || (wr_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state  <= FILL;
      em_state  <= IDLE;
      blk_buf   <= '0;
      sym_reg   <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      blk_err_q <= 1'b0;
    end else begin
      blk_err_q <= 1'b0;

      if (cap) begin
        sym_reg  <= rle_dout;
        blk_buf  <= '0;
        wr_cnt   <= '0;
        in_state <= FILL;
      end else if (accept) begin
        blk_buf[8*int'(wr_cnt) +: 8] <= strm.in_data;
        if (strm.in_last || (wr_cnt == LAST_IDX)) begin
          // Framing error when in_last and the final index disagree.
          in_state  <= FULL;
          blk_err_q <= strm.in_last != (wr_cnt == LAST_IDX);
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      if (fire) begin
        if (sym_last) begin
          rd_cnt   <= '0;
          em_state <= cap ? EMIT : IDLE;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end else if (cap) begin
        rd_cnt   <= '0;
        em_state <= EMIT;
      end
    end
  end
endmodule

// File: tb/tb_rle_stream_ctrl.sv
// Scoreboard bench for rle_stream_ctrl with a behavioural RLE model on rle_din/rle_dout.
// Symbols are {run[5:0], value[7:0]} per nonzero coefficient, then EOB.
module tb_rle_stream_ctrl;
  localparam int               NCOEF = 64;
  localparam int               SYM_W = 14;
  localparam logic [SYM_W-1:0] EOB   = 14'h3FFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rle_stream_if #(.SYM_W(SYM_W)) strm ();
  logic [NCOEF*8-1:0]     rle_din;
  logic [NCOEF*SYM_W-1:0] rle_dout;
  logic                   blk_err;
  logic                   busy;

  rle_stream_ctrl #(.NCOEF(NCOEF), .SYM_W(SYM_W), .EOB_SYM(EOB)) dut (
    .clk(clk), .rst_n(rst_n), .strm(strm),
    .rle_din(rle_din), .rle_dout(rle_dout),
    .blk_err(blk_err), .busy(busy)
  );

  function automatic logic [NCOEF*SYM_W-1:0] rle_model(input logic [NCOEF*8-1:0] din);
    logic [NCOEF*SYM_W-1:0] r;
    int run;
    int s;
    logic [7:0] v;
    r = '0;
    run = 0;
    s = 0;
    for (int k = 0; k < NCOEF; k++) begin
      v = din[8*k +: 8];
      if (v != 8'h00) begin
        if (s < NCOEF) r[SYM_W*(NCOEF-1-s) +: SYM_W] = {6'(run), v};
        s++;
        run = 0;
      end else begin
        run++;
      end
    end
    if (s < NCOEF) r[SYM_W*(NCOEF-1-s) +: SYM_W] = EOB;
    return r;
  endfunction

  assign rle_dout = rle_model(rle_din);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [SYM_W:0] exp_q[$];
  logic [7:0]     stim[NCOEF];
  int             err_cnt = 0;
  bit             rdy_rand = 1'b0;

  function automatic void push_expected(input int n);
    int run;
    int cnt;
    logic [7:0] v;
    run = 0;
    cnt = 0;
    for (int k = 0; k < NCOEF; k++) begin
      v = (k < n) ? stim[k] : 8'h00;
      if (v != 8'h00) begin
        if (cnt < NCOEF) exp_q.push_back({(cnt == NCOEF-1), 6'(run), v});
        cnt++;
        run = 0;
      end else begin
        run++;
      end
    end
    if (cnt < NCOEF) exp_q.push_back({1'b1, EOB});
  endfunction

  task automatic fill_zero();
    for (int k = 0; k < NCOEF; k++) stim[k] = 8'h00;
  endtask

  task automatic fill_case2();
    fill_zero();
    stim[0] = 8'd5;
    stim[3] = 8'hFE;
  endtask

  task automatic fill_dense(input int off);
    for (int k = 0; k < NCOEF; k++) stim[k] = 8'(k + 1 + off);
  endtask

  task automatic fill_sparse();
    for (int k = 0; k < NCOEF; k++)
      stim[k] = ($urandom_range(0, 9) < 3) ? 8'($urandom_range(1, 200)) : 8'h00;
  endtask

  // Called at a drive point (#1 after a rising edge); returns at the drive point
  // following the edge that accepted the final byte.
  task automatic send_block(input int n, input bit with_last);
    int w;
    push_expected(n);
    for (int i = 0; i < n; i++) begin
      strm.in_valid = 1'b1;
      strm.in_data  = stim[i];
      strm.in_last  = with_last && (i == n - 1);
      w = 0;
      while (!strm.in_ready && w < 2000) begin
        @(posedge clk); #1;
        w++;
      end
      if (!strm.in_ready) begin
        check("in_ready_wait", strm.in_ready, 1);
        break;
      end
      @(posedge clk); #1;
    end
    strm.in_valid = 1'b0;
    strm.in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check({"drain_", tag}, exp_q.size() + int'(busy), 0);
  endtask

  initial begin
    strm.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      strm.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic             prev_stall;
  logic [SYM_W-1:0] prev_sym;
  logic             prev_last;
  logic             prev_blk;
  logic             prev_cap_hs;
  logic             prev_cap_idle;
  logic [SYM_W:0]   e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall    = 1'b0;
      prev_blk      = 1'b0;
      prev_cap_hs   = 1'b0;
      prev_cap_idle = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", strm.out_valid, 1);
        check("stall_sym", strm.out_sym, prev_sym);
        check("stall_last", strm.out_last, prev_last);
      end
      if (prev_cap_hs) check("no_bubble", strm.out_valid, 1);
      if (prev_cap_idle) begin
        check("capture_in_ready", strm.in_ready, 1);
        check("capture_out_valid", strm.out_valid, 1);
      end
      if (blk_err) begin
        err_cnt++;
        check("blk_err_width", prev_blk, 0);
      end
      if (strm.out_valid && strm.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sym_qdepth", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sym", strm.out_sym, e[SYM_W-1:0]);
          check("sym_last", strm.out_last, e[SYM_W]);
        end
      end
      prev_stall    = strm.out_valid && !strm.out_ready;
      prev_sym      = strm.out_sym;
      prev_last     = strm.out_last;
      prev_blk      = blk_err;
      prev_cap_hs   = !strm.in_ready && strm.out_valid && strm.out_ready && strm.out_last;
      prev_cap_idle = !strm.in_ready && !strm.out_valid;
    end
  end

  int e0;

  initial begin
    strm.in_valid = 1'b0;
    strm.in_data  = 8'h00;
    strm.in_last  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", strm.in_ready, 1);
    check("rst_out_valid", strm.out_valid, 0);
    check("rst_out_sym", strm.out_sym, 0);
    check("rst_out_last", strm.out_last, 0);
    check("rst_blk_err", blk_err, 0);
    check("rst_busy", busy, 0);
    check("rst_rle_din_nonzero", (rle_din != '0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero block: EOB only, first symbol at T+2.
    fill_zero();
    send_block(64, 1'b1);
    @(negedge clk);
    check("lat_t1_valid", strm.out_valid, 0);
    @(negedge clk);
    check("lat_t2_valid", strm.out_valid, 1);
    check("lat_t2_sym", strm.out_sym, EOB);
    check("lat_t2_last", strm.out_last, 1);
    wait_drain("zero");

    fill_case2();
    send_block(64, 1'b1);
    wait_drain("case2");

    for (int b = 0; b < 3; b++) begin
      fill_dense(b * 3);
      send_block(64, 1'b1);
    end
    fill_sparse();
    send_block(64, 1'b1);
    wait_drain("b2b");

    rdy_rand = 1'b1;
    fill_case2();
    send_block(64, 1'b1);
    for (int b = 0; b < 3; b++) begin
      fill_dense(b * 5 + 1);
      send_block(64, 1'b1);
    end
    wait_drain("random_ready");
    rdy_rand = 1'b0;

    // Early in_last on byte 10: tail must read as zero.
    e0 = err_cnt;
    fill_dense(20);
    send_block(11, 1'b1);
    @(negedge clk);
    check("early_blk_err", blk_err, 1);
    check("early_tail_nonzero", (rle_din[NCOEF*8-1:88] != '0), 0);
    check("early_byte10", rle_din[87:80], 8'(10 + 1 + 20));
    @(negedge clk);
    check("early_blk_err_drop", blk_err, 0);
    wait_drain("early_last");

    fill_case2();
    send_block(64, 1'b0);
    @(negedge clk);
    check("nolast_blk_err", blk_err, 1);
    wait_drain("no_last");
    check("blk_err_count", err_cnt - e0, 2);

    // Reset in the middle of an emission.
    @(posedge clk); #1;
    fill_dense(40);
    send_block(64, 1'b1);
    repeat (12) @(negedge clk);
    #2;
    check("pre_reset_valid", strm.out_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", strm.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", strm.in_ready, 1);
    check("mid_rst_out_last", strm.out_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_case2();
    send_block(64, 1'b1);
    wait_drain("after_reset");
    check("final_blk_err_count", err_cnt - e0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
